time_keeper: RTL
================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000, meaning clk cycles per second tick; legal range 2 to 2^26.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port run  input  1  1 = timekeeping advances; 0 = prescaler and time frozen.
REQ-005 SHALL have port set_valid  input  1  request to load set_hours/set_minutes/set_seconds.
REQ-006 SHALL have port set_hours  input  5  load value for hours.
REQ-007 SHALL have port set_minutes  input  6  load value for minutes.
REQ-008 SHALL have port set_seconds  input  6  load value for seconds.
REQ-009 SHALL have port seconds  output  6  current seconds, 0..59, registered.
REQ-010 SHALL have port minutes  output  6  current minutes, 0..59, registered.
REQ-011 SHALL have port hours  output  5  current hours, 0..23, registered.
REQ-012 SHALL have port sec_tick  output  1  one-cycle pulse, same cycle seconds takes its new value.
REQ-013 SHALL have port day_roll  output  1  one-cycle pulse, same cycle time wraps 23:59:59 -> 00:00:00.
REQ-014 SHALL have port set_err  output  1  one-cycle pulse, cycle after an out-of-range set request.

Function
REQ-015 SHALL contain a prescaler counter counting 0..CLK_DIV-1 while run=1, holding its value while run=0.
REQ-016 SHALL generate an internal tick when run=1 and prescaler = CLK_DIV-1; prescaler SHALL return to 0 on that edge.
REQ-017 On tick, seconds SHALL increment; 59 -> 0 with carry to minutes.
REQ-018 On minutes carry, minutes SHALL increment; 59 -> 0 with carry to hours.
REQ-019 On hours carry, hours SHALL increment; 23 -> 0 and day_roll SHALL pulse.
REQ-020 All carries SHALL resolve in the tick edge; seconds/minutes/hours SHALL never show intermediate values.
REQ-021 sec_tick SHALL be registered, asserted exactly on the edge following a tick (aligned with updated seconds), otherwise 0.
REQ-022 set_valid=1 with set_hours<=23, set_minutes<=59, set_seconds<=59 SHALL load all three outputs on that edge and clear prescaler to 0.
REQ-023 A valid set SHALL take priority over a coincident tick; no increment, no sec_tick, no day_roll that cycle.
REQ-024 set_valid=1 with any field out of range SHALL leave time and prescaler unchanged (tick proceeds normally) and pulse set_err.
REQ-025 A set SHALL be accepted regardless of run; set_valid held high SHALL reload every cycle.
REQ-026 Output width SHALL be exact; no arithmetic SHALL produce values outside the stated ranges under any input.

Reset
REQ-027 With rst_n=0 at a rising edge: seconds=0, minutes=0, hours=0, prescaler=0, sec_tick=0, day_roll=0, set_err=0.
REQ-028 Reset SHALL override set_valid and tick in the same cycle.
REQ-029 Reset asserted mid-count SHALL discard prescaler progress; first tick after release occurs CLK_DIV cycles after the first run=1 edge.

Verification (CLK_DIV=4 for all)
REQ-030 Reset, run=1 for 12 cycles -> sec_tick pulses on cycles 4, 8, 12; seconds reads 1, 2, 3.
REQ-031 Set 23:59:58, run=1 -> after 4 cycles 23:59:59; after 8 cycles 00:00:00 with day_roll=1 for one cycle, sec_tick=1 same cycle.
REQ-032 Set 10:59:59 asserted on the same edge as a tick -> outputs 10:59:59, no sec_tick; next tick 4 cycles later -> 11:00:00.
REQ-033 set_valid with set_hours=24 (others 0) at 05:06:07 -> time unchanged, set_err=1 one cycle later; set_minutes=60 likewise.
REQ-034 run=1 for 2 cycles, run=0 for 10 cycles, run=1 -> first sec_tick exactly 2 run-cycles after resume; time unchanged while frozen.
REQ-035 Reset asserted at prescaler=2 with time 12:34:56 -> 00:00:00, no sec_tick until 4 cycles of run=1 after release.

Source files
------------

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
//
// Purpose:
//   Time-of-day clock (hh:mm:ss, 24-hour) driven by a prescaler that turns
//   CLK_DIV clk cycles into one second. The time can be loaded at any moment
//   through a set request. Out-of-range set requests are rejected and
//   reported.
//
// Parameters:
//   CLK_DIV      clk cycles per second tick, legal range 2 .. 2**26
//
// Ports:
//   clk          in   1  sole clock, all state updates on the rising edge
//   rst_n        in   1  synchronous active-low reset
//   run          in   1  1 = prescaler and time advance, 0 = both frozen
//   set_valid    in   1  request to load set_hours/set_minutes/set_seconds
//   set_hours    in   5  load value for hours   (accepted when <= 23)
//   set_minutes  in   6  load value for minutes (accepted when <= 59)
//   set_seconds  in   6  load value for seconds (accepted when <= 59)
//   seconds      out  6  current seconds 0..59, registered
//   minutes      out  6  current minutes 0..59, registered
//   hours        out  5  current hours   0..23, registered
//   sec_tick     out  1  one-cycle pulse, aligned with seconds changing
//   day_roll     out  1  one-cycle pulse, aligned with 23:59:59 -> 00:00:00
//   set_err      out  1  one-cycle pulse, cycle after a rejected set request
//
// Set request protocol:
//   set_valid has no ready companion; the block is always able to accept.
//   Every cycle set_valid is high at a rising edge counts as one request and
//   is acted on at that edge: a fully in-range request loads the time and
//   clears the prescaler, an out-of-range request changes nothing and raises
//   set_err for the following cycle. Holding set_valid high therefore reloads
//   (or re-reports) every cycle.
// -----------------------------------------------------------------------------
module time_keeper #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_valid,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       sec_tick,
  output logic       day_roll,
  output logic       set_err
);

  // Prescaler width: enough bits to hold CLK_DIV-1.
  localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic [4:0]    r_hour;
  logic          r_sec_tick;
  logic          r_day_roll;
  logic          r_set_err;

  // ---------------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------------
  logic          w_tick;
  logic          w_set_in_range;
  logic          w_set_ok;
  logic          w_set_bad;
  logic [PW-1:0] w_presc_nxt;
  logic [5:0]    w_sec_nxt;
  logic [5:0]    w_min_nxt;
  logic [4:0]    w_hour_nxt;
  logic          w_sec_tick_nxt;
  logic          w_day_roll_nxt;

  assign w_tick         = run && (r_presc == PRESC_MAX);
  assign w_set_in_range = (set_hours   <= HOUR_MAX) &&
                          (set_minutes <= MIN_MAX)  &&
                          (set_seconds <= SEC_MAX);
  assign w_set_ok       = set_valid && w_set_in_range;
  assign w_set_bad      = set_valid && !w_set_in_range;

  // Prescaler: cleared by an accepted set, wraps on tick, counts while run,
  // otherwise holds. Using >= for the wrap keeps the counter inside its range
  // even if it ever held a value past PRESC_MAX.
  always_comb begin
    w_presc_nxt = r_presc;
    if (w_set_ok) begin
      w_presc_nxt = '0;
    end else if (run) begin
      if (r_presc >= PRESC_MAX) begin
        w_presc_nxt = '0;
      end else begin
        w_presc_nxt = r_presc + 1'b1;
      end
    end
  end

  // Time counters: the whole seconds->minutes->hours carry chain is resolved
  // combinationally so the registered outputs jump straight to the final
  // value on the tick edge. An accepted set wins over a coincident tick and
  // suppresses both pulses for that edge.
  always_comb begin
    w_sec_nxt      = r_sec;
    w_min_nxt      = r_min;
    w_hour_nxt     = r_hour;
    w_sec_tick_nxt = 1'b0;
    w_day_roll_nxt = 1'b0;
    if (w_set_ok) begin
      w_sec_nxt  = set_seconds;
      w_min_nxt  = set_minutes;
      w_hour_nxt = set_hours;
    end else if (w_tick) begin
      w_sec_tick_nxt = 1'b1;
      if (r_sec >= SEC_MAX) begin
        w_sec_nxt = 6'd0;
        if (r_min >= MIN_MAX) begin
          w_min_nxt = 6'd0;
          if (r_hour >= HOUR_MAX) begin
            w_hour_nxt     = 5'd0;
            w_day_roll_nxt = 1'b1;
          end else begin
            w_hour_nxt = r_hour + 5'd1;
          end
        end else begin
          w_min_nxt = r_min + 6'd1;
        end
      end else begin
        w_sec_nxt = r_sec + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential update; reset overrides any set request or tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_sec      <= 6'd0;
      r_min      <= 6'd0;
      r_hour     <= 5'd0;
      r_sec_tick <= 1'b0;
      r_day_roll <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_sec      <= w_sec_nxt;
      r_min      <= w_min_nxt;
      r_hour     <= w_hour_nxt;
      r_sec_tick <= w_sec_tick_nxt;
      r_day_roll <= w_day_roll_nxt;
      r_set_err  <= w_set_bad;
    end
  end

  assign seconds  = r_sec;
  assign minutes  = r_min;
  assign hours    = r_hour;
  assign sec_tick = r_sec_tick;
  assign day_roll = r_day_roll;
  assign set_err  = r_set_err;

endmodule
